// File: rtl/tnoc_axi_types_pkg.sv
// Shared AXI types and limits for the tnoc write-path blocks.
package tnoc_axi_types_pkg;

  typedef struct packed {
    int id_width;
    int address_width;
    int data_width;
  } tnoc_config;

  localparam tnoc_config TNOC_DEFAULT_CONFIG = '{id_width: 4, address_width: 32, data_width: 32};

  localparam int TNOC_AXI_MAX_OUTSTANDING_LIMIT = 64;

  typedef logic [7:0] tnoc_axi_burst_length;

endpackage

// File: rtl/tnoc_axi_write_if.sv
// AXI4 write-channel bundle (AW/W/B) sized from a tnoc_config.
interface tnoc_axi_write_if #(
  parameter tnoc_axi_types_pkg::tnoc_config CONFIG = tnoc_axi_types_pkg::TNOC_DEFAULT_CONFIG
) ();
  logic                                awvalid;
  logic                                awready;
  logic [CONFIG.id_width-1:0]          awid;
  logic [CONFIG.address_width-1:0]     awaddr;
  tnoc_axi_types_pkg::tnoc_axi_burst_length awlen;
  logic [2:0]                          awsize;
  logic [1:0]                          awburst;
  logic                                wvalid;
  logic                                wready;
  logic [CONFIG.data_width-1:0]        wdata;
  logic [CONFIG.data_width/8-1:0]      wstrb;
  logic                                wlast;
  logic                                bvalid;
  logic                                bready;
  logic [CONFIG.id_width-1:0]          bid;
  logic [1:0]                          bresp;

  modport master (
    output awvalid, awid, awaddr, awlen, awsize, awburst, input awready,
    output wvalid, wdata, wstrb, wlast, input wready,
    input bvalid, bid, bresp, output bready
  );
  modport slave (
    input awvalid, awid, awaddr, awlen, awsize, awburst, output awready,
    input wvalid, wdata, wstrb, wlast, output wready,
    output bvalid, bid, bresp, input bready
  );
endinterface

// File: rtl/tnoc_axi_burst_length_fifo.sv
// First-word fall-through FIFO holding AWLEN of forwarded bursts.
module tnoc_axi_burst_length_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push, do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign data_out = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= data_in;
  end
endmodule

// File: rtl/tnoc_axi_write_outstanding_gate.sv
// Caps outstanding AXI writes, holds W until its AW is forwarded, regenerates WLAST.
// Optional upstream WLAST checker enabled by TNOC_AXI_WLAST_CHECK_EN.
module tnoc_axi_write_outstanding_gate
  import tnoc_axi_types_pkg::*;
#(
  parameter tnoc_config CONFIG          = TNOC_DEFAULT_CONFIG,
  parameter int         MAX_OUTSTANDING = 4
) (
  input  logic  clk,
  input  logic  rst,
  tnoc_axi_write_if.slave  slave_if,
  tnoc_axi_write_if.master master_if,
  output logic  o_wlast_error
);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > TNOC_AXI_MAX_OUTSTANDING_LIMIT) begin : g_bad_max
    $error("MAX_OUTSTANDING out of range");
  end

  logic [OW-1:0]               outstanding;
  logic [8:0]                  beat;
  tnoc_axi_burst_length        head_len;
  logic                        fifo_full, fifo_empty;
  logic                        aw_ok, w_ok, aw_hs, w_hs, b_hs, wlast_gen;
  logic [CONFIG.id_width-1:0]      aw_id, b_id;
  logic [CONFIG.address_width-1:0] aw_addr;
  logic [CONFIG.data_width-1:0]    w_data;
  logic [CONFIG.data_width/8-1:0]  w_strb;

  assign aw_ok = (outstanding < OW'(MAX_OUTSTANDING)) && !fifo_full;
  assign w_ok  = !fifo_empty;

  assign master_if.awvalid = slave_if.awvalid && aw_ok;
  assign slave_if.awready  = master_if.awready && aw_ok;
  assign aw_id             = slave_if.awid;
  assign aw_addr           = slave_if.awaddr;
  assign master_if.awid    = aw_id;
  assign master_if.awaddr  = aw_addr;
  assign master_if.awlen   = slave_if.awlen;
  assign master_if.awsize  = slave_if.awsize;
  assign master_if.awburst = slave_if.awburst;

  assign master_if.wvalid = slave_if.wvalid && w_ok;
  assign slave_if.wready  = master_if.wready && w_ok;
  assign w_data           = slave_if.wdata;
  assign w_strb           = slave_if.wstrb;
  assign master_if.wdata  = w_data;
  assign master_if.wstrb  = w_strb;
  assign wlast_gen        = (beat == {1'b0, head_len});
  assign master_if.wlast  = wlast_gen;

  assign slave_if.bvalid  = master_if.bvalid;
  assign master_if.bready = slave_if.bready;
  assign b_id             = master_if.bid;
  assign slave_if.bid     = b_id;
  assign slave_if.bresp   = master_if.bresp;

  assign aw_hs = master_if.awvalid && master_if.awready;
  assign w_hs  = master_if.wvalid && master_if.wready;
  assign b_hs  = master_if.bvalid && master_if.bready;

  // W only ever sees the head registered before this cycle's push.
  tnoc_axi_burst_length_fifo #(.DEPTH(MAX_OUTSTANDING), .WIDTH(8)) u_len_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (aw_hs),
    .pop      (w_hs && wlast_gen),
    .data_in  (slave_if.awlen),
    .data_out (head_len),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
      beat        <= '0;
    end else begin
      if (aw_hs && !b_hs)                           outstanding <= outstanding + OW'(1);
      else if (b_hs && !aw_hs && outstanding != '0) outstanding <= outstanding - OW'(1);
      if (w_hs) beat <= wlast_gen ? 9'd0 : beat + 9'd1;
    end
  end

  a_b_without_aw: assert property (@(posedge clk) disable iff (rst) b_hs |-> (outstanding != '0));

`ifdef TNOC_AXI_WLAST_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) o_wlast_error <= 1'b0;
    else     o_wlast_error <= w_hs && (slave_if.wlast != wlast_gen);
  end
`else
  logic unused_wlast;
  assign unused_wlast  = slave_if.wlast;
  assign o_wlast_error = 1'b0;
`endif
endmodule

// File: tb/tb_tnoc_axi_write_outstanding_gate.sv
// Directed bench for the AXI write outstanding gate (MAX_OUTSTANDING = 4).
module tb_tnoc_axi_write_outstanding_gate;
  import tnoc_axi_types_pkg::*;

`ifdef TNOC_AXI_WLAST_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic o_wlast_error;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  tnoc_axi_write_if up_if ();
  tnoc_axi_write_if dn_if ();

  tnoc_axi_write_outstanding_gate #(.CONFIG(TNOC_DEFAULT_CONFIG), .MAX_OUTSTANDING(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .slave_if      (up_if),
    .master_if     (dn_if),
    .o_wlast_error (o_wlast_error)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_b(input int n);
    for (int i = 0; i < n; i++) begin
      dn_if.bvalid = 1'b1;
      cyc();
      dn_if.bvalid = 1'b0;
    end
  endtask

  task automatic test_reset();
    up_if.awvalid = 0; up_if.awid = 0; up_if.awaddr = 0; up_if.awlen = 0;
    up_if.awsize = 3'd2; up_if.awburst = 2'd1;
    up_if.wvalid = 0; up_if.wdata = 0; up_if.wstrb = 4'hf; up_if.wlast = 0;
    up_if.bready = 1;
    dn_if.awready = 1; dn_if.wready = 1; dn_if.bvalid = 0; dn_if.bid = 0; dn_if.bresp = 0;
    rst = 1;
    cyc(); cyc();
    n_vec++; if (dn_if.awvalid !== 1'b0) begin n_err++; $display("FAIL reset_awvalid got %b exp 0", dn_if.awvalid); end
    n_vec++; if (dn_if.wvalid !== 1'b0) begin n_err++; $display("FAIL reset_wvalid got %b exp 0", dn_if.wvalid); end
    n_vec++; if (up_if.bvalid !== 1'b0) begin n_err++; $display("FAIL reset_bvalid got %b exp 0", up_if.bvalid); end
    n_vec++; if (o_wlast_error !== 1'b0) begin n_err++; $display("FAIL reset_wlast_error got %b exp 0", o_wlast_error); end
    n_vec++; if (dut.outstanding !== 3'd0) begin n_err++; $display("FAIL reset_outstanding got %0d exp 0", dut.outstanding); end
    rst = 0;
    cyc();
  endtask

  task automatic test_single_burst();
    up_if.awvalid = 1; up_if.awlen = 8'd3; up_if.awaddr = 32'h1000; up_if.awid = 4'h3;
    #1;
    n_vec++; if (dn_if.awvalid !== 1'b1 || up_if.awready !== 1'b1) begin n_err++; $display("FAIL single_aw got v%b r%b exp v1 r1", dn_if.awvalid, up_if.awready); end
    n_vec++; if (dn_if.awaddr !== 32'h1000 || dn_if.awid !== 4'h3) begin n_err++; $display("FAIL single_aw_fields got %h/%h exp 1000/3", dn_if.awaddr, dn_if.awid); end
    cyc();
    up_if.awvalid = 0;
    n_vec++; if (dut.outstanding !== 3'd1) begin n_err++; $display("FAIL single_outstanding1 got %0d exp 1", dut.outstanding); end
    for (int i = 0; i < 4; i++) begin
      up_if.wvalid = 1; up_if.wdata = 32'hA0 + i; up_if.wlast = (i == 3);
      #1;
      n_vec++; if (dn_if.wvalid !== 1'b1 || dn_if.wdata !== 32'hA0 + i) begin n_err++; $display("FAIL single_w%0d got v%b d%h exp v1 d%h", i, dn_if.wvalid, dn_if.wdata, 32'hA0 + i); end
      n_vec++; if (dn_if.wlast !== (i == 3)) begin n_err++; $display("FAIL single_wlast%0d got %b exp %b", i, dn_if.wlast, (i == 3)); end
      cyc();
    end
    up_if.wvalid = 1; up_if.wlast = 0;
    #1;
    n_vec++; if (dn_if.wvalid !== 1'b0 || up_if.wready !== 1'b0) begin n_err++; $display("FAIL single_extra_w got v%b r%b exp 0 0", dn_if.wvalid, up_if.wready); end
    up_if.wvalid = 0;
    dn_if.bvalid = 1; dn_if.bid = 4'h3; dn_if.bresp = 2'd2;
    #1;
    n_vec++; if (up_if.bvalid !== 1'b1 || up_if.bid !== 4'h3 || up_if.bresp !== 2'd2) begin n_err++; $display("FAIL single_b got v%b id%h r%0d exp 1 3 2", up_if.bvalid, up_if.bid, up_if.bresp); end
    cyc();
    dn_if.bvalid = 0; dn_if.bresp = 0;
    n_vec++; if (dut.outstanding !== 3'd0) begin n_err++; $display("FAIL single_outstanding0 got %0d exp 0", dut.outstanding); end
  endtask

  task automatic test_early_w();
    up_if.wvalid = 1; up_if.wdata = 32'h55; up_if.wlast = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_vec++; if (up_if.wready !== 1'b0) begin n_err++; $display("FAIL early_wready%0d got %b exp 0", i, up_if.wready); end
      cyc();
    end
    up_if.awvalid = 1; up_if.awlen = 8'd0;
    #1;
    n_vec++; if (up_if.wready !== 1'b0 || up_if.awready !== 1'b1) begin n_err++; $display("FAIL early_aw_cycle got wr%b awr%b exp 0 1", up_if.wready, up_if.awready); end
    cyc();
    up_if.awvalid = 0;
    #1;
    n_vec++; if (up_if.wready !== 1'b1 || dn_if.wlast !== 1'b1) begin n_err++; $display("FAIL early_w_next got wr%b wl%b exp 1 1", up_if.wready, dn_if.wlast); end
    cyc();
    #1;
    n_vec++; if (dn_if.wvalid !== 1'b0) begin n_err++; $display("FAIL early_single_beat got %b exp 0", dn_if.wvalid); end
    up_if.wvalid = 0; up_if.wlast = 0;
    send_b(1);
  endtask

  task automatic test_saturation();
    up_if.awvalid = 1; up_if.awlen = 8'd0;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_vec++; if (up_if.awready !== 1'b1) begin n_err++; $display("FAIL sat_aw%0d got %b exp 1", i, up_if.awready); end
      cyc();
    end
    #1;
    n_vec++; if (up_if.awready !== 1'b0 || dn_if.awvalid !== 1'b0) begin n_err++; $display("FAIL sat_fifth_held got r%b v%b exp 0 0", up_if.awready, dn_if.awvalid); end
    // Drain the length FIFO so only the outstanding count is holding AW.
    up_if.wvalid = 1; up_if.wlast = 1;
    for (int i = 0; i < 4; i++) cyc();
    up_if.wvalid = 0;
    #1;
    n_vec++; if (up_if.awready !== 1'b0 || dut.outstanding !== 3'd4) begin n_err++; $display("FAIL sat_after_w got r%b o%0d exp 0 4", up_if.awready, dut.outstanding); end
    dn_if.bvalid = 1;
    #1;
    n_vec++; if (up_if.awready !== 1'b0) begin n_err++; $display("FAIL sat_b_cycle got %b exp 0", up_if.awready); end
    cyc();
    dn_if.bvalid = 0;
    #1;
    n_vec++; if (up_if.awready !== 1'b1 || dn_if.awvalid !== 1'b1) begin n_err++; $display("FAIL sat_fifth_released got r%b v%b exp 1 1", up_if.awready, dn_if.awvalid); end
    cyc();
    up_if.awvalid = 0;
    n_vec++; if (dut.outstanding !== 3'd4) begin n_err++; $display("FAIL sat_outstanding got %0d exp 4", dut.outstanding); end
    up_if.wvalid = 1;
    cyc();
    up_if.wvalid = 0; up_if.wlast = 0;
    send_b(4);
    n_vec++; if (dut.outstanding !== 3'd0) begin n_err++; $display("FAIL sat_drained got %0d exp 0", dut.outstanding); end
  endtask

  task automatic test_concurrency();
    int lens [3];
    int k;
    lens = '{1, 7, 0};
    for (int i = 0; i < 2; i++) begin
      up_if.awvalid = 1; up_if.awlen = 8'(lens[i]);
      cyc();
    end
    n_vec++; if (dut.outstanding !== 3'd2) begin n_err++; $display("FAIL conc_pre got %0d exp 2", dut.outstanding); end
    up_if.awlen = 8'(lens[2]); dn_if.bvalid = 1;
    #1;
    n_vec++; if (up_if.awready !== 1'b1 || up_if.bvalid !== 1'b1) begin n_err++; $display("FAIL conc_both got awr%b bv%b exp 1 1", up_if.awready, up_if.bvalid); end
    cyc();
    up_if.awvalid = 0; dn_if.bvalid = 0;
    n_vec++; if (dut.outstanding !== 3'd2) begin n_err++; $display("FAIL conc_outstanding got %0d exp 2", dut.outstanding); end
    up_if.wvalid = 1; k = 0;
    for (int t = 0; t < 3; t++) begin
      for (int b = 0; b <= lens[t]; b++) begin
        up_if.wdata = 32'(k);
        #1;
        n_vec++; if (dn_if.wvalid !== 1'b1 || dn_if.wlast !== (b == lens[t])) begin n_err++; $display("FAIL conc_beat%0d got v%b l%b exp v1 l%b", k, dn_if.wvalid, dn_if.wlast, (b == lens[t])); end
        cyc();
        k++;
      end
    end
    up_if.wvalid = 0;
    #1;
    n_vec++; if (dn_if.wvalid !== 1'b0) begin n_err++; $display("FAIL conc_empty got %b exp 0", dn_if.wvalid); end
    send_b(2);
  endtask

  task automatic test_wlast_check();
    up_if.awvalid = 1; up_if.awlen = 8'd1;
    cyc();
    up_if.awvalid = 0;
    up_if.wvalid = 1; up_if.wlast = 1;
    #1;
    n_vec++; if (dn_if.wlast !== 1'b0 || o_wlast_error !== 1'b0) begin n_err++; $display("FAIL chk_beat0 got wl%b err%b exp 0 0", dn_if.wlast, o_wlast_error); end
    cyc();
    n_vec++; if (o_wlast_error !== CHECK_EN || dn_if.wlast !== 1'b1) begin n_err++; $display("FAIL chk_pulse got err%b wl%b exp %b 1", o_wlast_error, dn_if.wlast, CHECK_EN); end
    cyc();
    up_if.wvalid = 0; up_if.wlast = 0;
    n_vec++; if (o_wlast_error !== 1'b0) begin n_err++; $display("FAIL chk_one_cycle got %b exp 0", o_wlast_error); end
    send_b(1);
  endtask

  task automatic test_reset_mid_burst();
    up_if.awvalid = 1; up_if.awlen = 8'd3;
    cyc();
    up_if.awvalid = 0; up_if.wvalid = 1;
    cyc(); cyc();
    n_vec++; if (dut.beat !== 9'd2) begin n_err++; $display("FAIL rst_pre_beat got %0d exp 2", dut.beat); end
    rst = 1;
    cyc();
    rst = 0;
    n_vec++; if (dn_if.awvalid !== 1'b0 || dn_if.wvalid !== 1'b0 || up_if.bvalid !== 1'b0) begin n_err++; $display("FAIL rst_outputs got aw%b w%b b%b exp 0 0 0", dn_if.awvalid, dn_if.wvalid, up_if.bvalid); end
    n_vec++; if (dut.outstanding !== 3'd0 || dut.fifo_empty !== 1'b1 || dut.beat !== 9'd0) begin n_err++; $display("FAIL rst_state got o%0d e%b b%0d exp 0 1 0", dut.outstanding, dut.fifo_empty, dut.beat); end
    up_if.wvalid = 0;
    up_if.awvalid = 1; up_if.awlen = 8'd0;
    cyc();
    up_if.awvalid = 0; up_if.wvalid = 1; up_if.wlast = 1;
    #1;
    n_vec++; if (dn_if.wvalid !== 1'b1 || dn_if.wlast !== 1'b1) begin n_err++; $display("FAIL rst_new_burst got v%b l%b exp 1 1", dn_if.wvalid, dn_if.wlast); end
    cyc();
    up_if.wvalid = 0; up_if.wlast = 0;
    send_b(1);
    n_vec++; if (dut.outstanding !== 3'd0) begin n_err++; $display("FAIL rst_final got %0d exp 0", dut.outstanding); end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_early_w();
    test_saturation();
    test_concurrency();
    test_wlast_check();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
